memreq_issue: RTL and testbench
===============================

# memreq_issue

Per-port request issuer sitting directly upstream of the tile memory block (`memblk`). It accepts read and write requests from one core-side port via valid/ready, buffers them in two small FIFOs and drives one lane of `memblk`'s `rdaddr0`/`rdphydata0`/`rden_in` and `wraddr0`/`wrdata`/`wren_in` inputs. It honours `memblk`'s global `stall` and limits in-flight reads with a credit counter returned by `rden_out`. The tile instantiates 36 copies, one per lane.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, at least 2.
- `MAX_RD_OUT`, 63: maximum reads issued but not yet returned; at most 63.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  `memblk` stall; no issue is counted while high.
- `req_rd_valid` / `req_rd_ready`  in/out  1  read request handshake.
- `req_rd_addr`  in  39  read address; bit 37 is the `memblk` share-on-read flag.
- `req_rd_phy`  in  40  physical tag data passed through to `rdphydata0`.
- `req_wr_valid` / `req_wr_ready`  in/out  1  write request handshake.
- `req_wr_addr`  in  39  write address.
- `req_wr_data`  in  533  line data plus 5 extra bits (8*66+5).
- `mem_rdaddr0`, `mem_rdphydata0`, `mem_rden`  out  39/40/1  to `memblk` read lane.
- `mem_wraddr0`, `mem_wrdata`, `mem_wren`  out  39/533/1  to `memblk` write lane.
- `rsp_rden`  in  1  `rden_out` of this lane; one pulse per returned read.
- `rd_outstanding`  out  6  current read credit count.
- `idle`  out  1  both FIFOs are empty and `rd_outstanding` is 0.
- `cnt_err`  out  1  sticky: `rsp_rden` arrived while `rd_outstanding` was 0.

## Operation
- **FIFO push**
  - Each FIFO pushes on `valid && ready`.
  - `ready` = not full, computed from the registered count only. A full FIFO does not push even if it pops in the same cycle.
- **Head drive**
  - `mem_*addr0`/data are driven from the FIFO head storage.
  - When the FIFO is empty, `mem_rden`/`mem_wren` = 0 and the data outputs hold their last head value.
- **Read issue**
  - `mem_rden` = read FIFO non-empty && `rd_outstanding < MAX_RD_OUT` && no RAW hold (see Configuration).
  - The read pops on `mem_rden && !stall`.
- **Write issue**
  - `mem_wren` = write FIFO non-empty.
  - The write pops on `mem_wren && !stall`.
- **Independence:** read and write lanes issue in the same cycle independently.
- **Stall:** while `stall` = 1, head, enables and outputs stay stable, because `memblk` samples its inputs only when not stalled.
- **Credit counter `rd_outstanding`**
  - +1 on read pop; −1 on `rsp_rden`; both in the same cycle leaves it unchanged.
  - `rsp_rden` at 0 holds the counter at 0 and sets `cnt_err`.
  - `rsp_rden` is counted regardless of `stall`.
- **Pointers:** log2(DEPTH) bits, wrapping naturally; count is DEPTH+1 valued.

## Timing
- Reset (asynchronous, low):
  - FIFOs are emptied and the counter and `cnt_err` are cleared.
  - `mem_rden`, `mem_wren`, `idle`=1 and `rd_outstanding` take their reset values immediately.
  - `req_*_ready` = 1 after reset.
  - Reset asserted mid-operation discards all queued requests; in-flight returns after reset trip `cnt_err`.
- Latency: a request accepted at edge N drives `mem_*en` = 1 in cycle N+1 if the FIFO was empty and nothing blocks it.
- Throughput: one read and one write per unstalled cycle.
- `rd_outstanding` and `cnt_err` update at the clock edge after the event.

## Configuration
- `MEMREQ_RAW_ORDER_EN` defined:
  - The read head is held (`mem_rden` = 0) while any valid write-FIFO entry has `addr[36:4]` equal to the read head's `addr[36:4]`.
  - The hold releases in the cycle after that write pops.
  - A write pushed in the same cycle as a read push is treated as older.
- Not defined: no address comparison; reads and writes are fully independent and the comparator logic is absent.

## Structure
- `memreq_pkg` holds:
  - `ADDR_W`=39, `PHY_W`=40, `WDATA_W`=533.
  - `LINE_HI`=36, `LINE_LO`=4.
  - Read-entry and write-entry struct typedefs.
- Sub-module `memreq_fifo`: width/depth-parameterised synchronous FIFO with head output, full/empty and count; instantiated twice.
- `memreq_issue` holds the issue logic, credit counter and optional RAW comparator.

## Test plan
- **Basic issue:** read push addr 0x0000001230, no stall → `mem_rden` = 1 next cycle with that address; pops; `rd_outstanding` = 1; `rsp_rden` pulse → 0, `idle` = 1.
- **Stall hold:** push read and write, hold `stall` = 1 for 5 cycles → outputs constant, no pop, count unchanged; `stall` low → both pop the same cycle.
- **Full FIFO:** DEPTH=4, push 4 writes under stall → `req_wr_ready` = 0; a 5th push is refused; release stall → ready = 1 one cycle after the first pop.
- **Credit limit:** MAX_RD_OUT=2, push 3 reads, no returns → only 2 issue, third `mem_rden` = 0; one `rsp_rden` → third issues next cycle. Simultaneous issue and return keeps the count.
- **Error:** `rsp_rden` with count 0 → `cnt_err` = 1 and stays set until reset; async reset mid-queue → outputs cleared without a clock edge.
- **RAW (macro defined):** write line 0x40 queued under stall, then read 0x40 → `mem_rden` = 0 until the write pops, then 1. Macro off → both issue together.

Source files
------------

// File: rtl/memreq_pkg.sv
// Shared widths and entry types for the per-lane memblk request issuer.
// Line-index bounds select the address bits used for read-after-write ordering.
package memreq_pkg;

    localparam int ADDR_W  = 39;
    localparam int PHY_W   = 40;
    localparam int WDATA_W = 533;
    localparam int LINE_HI = 36;
    localparam int LINE_LO = 4;
    localparam int LINE_W  = LINE_HI - LINE_LO + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PHY_W-1:0]  phy;
    } rd_ent_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] data;
    } wr_ent_t;

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return a[LINE_HI:LINE_LO];
    endfunction

endpackage

// File: rtl/memreq_fifo.sv
// Purpose: generic synchronous FIFO exposing head storage, full/empty and count.
// Latency: a push into an empty FIFO is visible at the head in the next cycle.
// Backpressure: pushes are dropped while full (registered count), pops ignored while empty.
module memreq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp, hp;
    logic [PW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Once drained, keep presenting the entry that was popped last.
    assign hp   = empty ? rp - PW'(1) : rp;
    assign head = mem[hp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop)  rp <= rp + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= push_dat;
    end

endmodule

// File: rtl/memreq_issue.sv
// Purpose: per-lane read/write issuer into memblk with read credits; MEMREQ_RAW_ORDER_EN adds RAW hold.
// Latency: request accepted at edge N drives mem_*en in cycle N+1 when the FIFO was empty.
// Backpressure: req_*_ready is FIFO not-full; memblk stall freezes issue, reads also wait for credit.
module memreq_issue
    import memreq_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int MAX_RD_OUT = 63
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               req_rd_valid,
    output logic               req_rd_ready,
    input  logic [ADDR_W-1:0]  req_rd_addr,
    input  logic [PHY_W-1:0]   req_rd_phy,
    input  logic               req_wr_valid,
    output logic               req_wr_ready,
    input  logic [ADDR_W-1:0]  req_wr_addr,
    input  logic [WDATA_W-1:0] req_wr_data,
    output logic [ADDR_W-1:0]  mem_rdaddr0,
    output logic [PHY_W-1:0]   mem_rdphydata0,
    output logic               mem_rden,
    output logic [ADDR_W-1:0]  mem_wraddr0,
    output logic [WDATA_W-1:0] mem_wrdata,
    output logic               mem_wren,
    input  logic               rsp_rden,
    output logic [5:0]         rd_outstanding,
    output logic               idle,
    output logic               cnt_err
);

    localparam int         PW    = $clog2(DEPTH);
    localparam logic [5:0] MAX_C = 6'(MAX_RD_OUT);

    rd_ent_t     rd_in, rd_head;
    wr_ent_t     wr_in, wr_head;
    logic        rd_full, rd_empty, wr_full, wr_empty;
    logic [PW:0] rd_cnt, wr_cnt;
    logic        rd_push, wr_push, rd_pop, wr_pop;
    logic        raw_hold;
    logic        rsp_ok;

    assign rd_in   = '{addr: req_rd_addr, phy: req_rd_phy};
    assign wr_in   = '{addr: req_wr_addr, data: req_wr_data};
    assign rd_push = req_rd_valid && req_rd_ready;
    assign wr_push = req_wr_valid && req_wr_ready;

    memreq_fifo #(.W($bits(rd_ent_t)), .DEPTH(DEPTH)) u_rd_fifo (
        .clk(clk), .rst(rst), .push(rd_push), .push_dat(rd_in), .pop(rd_pop),
        .head(rd_head), .full(rd_full), .empty(rd_empty), .count(rd_cnt)
    );

    memreq_fifo #(.W($bits(wr_ent_t)), .DEPTH(DEPTH)) u_wr_fifo (
        .clk(clk), .rst(rst), .push(wr_push), .push_dat(wr_in), .pop(wr_pop),
        .head(wr_head), .full(wr_full), .empty(wr_empty), .count(wr_cnt)
    );

    assign req_rd_ready   = !rd_full;
    assign req_wr_ready   = !wr_full;
    assign mem_rdaddr0    = rd_head.addr;
    assign mem_rdphydata0 = rd_head.phy;
    assign mem_wraddr0    = wr_head.addr;
    assign mem_wrdata     = wr_head.data;

    assign mem_rden = !rd_empty && (rd_outstanding < MAX_C) && !raw_hold;
    assign mem_wren = !wr_empty;
    assign rd_pop   = mem_rden && !stall;
    assign wr_pop   = mem_wren && !stall;
    assign idle     = (rd_cnt == '0) && (wr_cnt == '0) && (rd_outstanding == '0);

`ifdef MEMREQ_RAW_ORDER_EN
    // Shadow of the queued write line indices, kept in lockstep with the write FIFO.
    logic [LINE_W-1:0] tag [DEPTH];
    logic [PW-1:0]     tag_wp, tag_rp, off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wp <= '0;
            tag_rp <= '0;
        end else begin
            if (wr_push) tag_wp <= tag_wp + PW'(1);
            if (wr_pop)  tag_rp <= tag_rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_push) tag[tag_wp] <= line_of(req_wr_addr);
    end

    always_comb begin
        raw_hold = 1'b0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - tag_rp;
            if (({1'b0, off} < wr_cnt) && (tag[i] == line_of(rd_head.addr)))
                raw_hold = 1'b1;
        end
    end
`else
    assign raw_hold = 1'b0;
`endif

    // A return seen with no reads in flight is spurious: flag it, don't decrement.
    assign rsp_ok = rsp_rden && (rd_outstanding != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_outstanding <= '0;
            cnt_err        <= 1'b0;
        end else begin
            if (rsp_rden && (rd_outstanding == '0)) cnt_err <= 1'b1;
            case ({rd_pop, rsp_ok})
                2'b10:   rd_outstanding <= rd_outstanding + 6'd1;
                2'b01:   rd_outstanding <= rd_outstanding - 6'd1;
                default: rd_outstanding <= rd_outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_memreq_issue.sv
// Directed table of per-cycle stimulus and expected lane outputs for memreq_issue (DEPTH=4, MAX_RD_OUT=2),
// followed by hand-written sequences for the sticky error flag and asynchronous reset.
module tb_memreq_issue;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         req_rd_valid, req_rd_ready;
    logic [38:0]  req_rd_addr;
    logic [39:0]  req_rd_phy;
    logic         req_wr_valid, req_wr_ready;
    logic [38:0]  req_wr_addr;
    logic [532:0] req_wr_data;
    logic [38:0]  mem_rdaddr0;
    logic [39:0]  mem_rdphydata0;
    logic         mem_rden;
    logic [38:0]  mem_wraddr0;
    logic [532:0] mem_wrdata;
    logic         mem_wren;
    logic         rsp_rden;
    logic [5:0]   rd_outstanding;
    logic         idle;
    logic         cnt_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memreq_issue #(.DEPTH(4), .MAX_RD_OUT(2)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
        .req_rd_addr(req_rd_addr), .req_rd_phy(req_rd_phy),
        .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
        .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
        .mem_rdaddr0(mem_rdaddr0), .mem_rdphydata0(mem_rdphydata0), .mem_rden(mem_rden),
        .mem_wraddr0(mem_wraddr0), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren),
        .rsp_rden(rsp_rden), .rd_outstanding(rd_outstanding), .idle(idle), .cnt_err(cnt_err)
    );

    typedef struct {
        logic        rv;
        logic [38:0] ra;
        logic        wv;
        logic [38:0] wa;
        logic        st;
        logic        rsp;
        logic        e_rden;
        logic        e_wren;
        logic [38:0] e_ra;
        logic [38:0] e_wa;
        logic [5:0]  e_out;
        logic        e_rrdy;
        logic        e_wrdy;
        logic        e_idle;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rv, input logic [38:0] ra, input logic wv, input logic [38:0] wa,
                                input logic st, input logic rsp, input logic e_rden, input logic e_wren,
                                input logic [38:0] e_ra, input logic [38:0] e_wa, input logic [5:0] e_out,
                                input logic e_rrdy, input logic e_wrdy, input logic e_idle);
        vec_t v;
        v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.st = st; v.rsp = rsp;
        v.e_rden = e_rden; v.e_wren = e_wren; v.e_ra = e_ra; v.e_wa = e_wa;
        v.e_out = e_out; v.e_rrdy = e_rrdy; v.e_wrdy = e_wrdy; v.e_idle = e_idle;
        return v;
    endfunction

    function automatic logic [39:0] phy_of(input logic [38:0] a);
        return {1'b1, a ^ 39'h55_5555_5555};
    endfunction

    function automatic logic [532:0] wdata_of(input logic [38:0] a);
        return {a, 455'd0, ~a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [38:0] ra, input logic wv, input logic [38:0] wa,
                         input logic st, input logic rsp);
        req_rd_valid = rv;
        req_rd_addr  = ra;
        req_rd_phy   = phy_of(ra);
        req_wr_valid = wv;
        req_wr_addr  = wa;
        req_wr_data  = wdata_of(wa);
        stall        = st;
        rsp_rden     = rsp;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        //        rv ra        wv wa       st rsp rden wren e_ra      e_wa     out rrdy wrdy idle
        // basic issue and return
        vt.push_back(mk(1, 'h1230, 0, 0,     0, 0,  0, 0, 0,      0,     0, 1, 1, 1));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  1, 0, 'h1230, 0,     0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 1,  0, 0, 0,      0,     1, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,     0, 1, 1, 1));
        // stall hold then simultaneous issue
        vt.push_back(mk(1, 'h2000, 1, 'h3000, 1, 0, 0, 0, 0,      0,      0, 1, 1, 1));
        for (int k = 0; k < 5; k++)
            vt.push_back(mk(0, 0,  0, 0,     1, 0,  1, 1, 'h2000, 'h3000, 0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  1, 1, 'h2000, 'h3000, 0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,      1, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 1,  0, 0, 0,      0,      1, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,      0, 1, 1, 1));
        // credit limit of 2
        vt.push_back(mk(1, 'h100,  0, 0,     0, 0,  0, 0, 0,      0,     0, 1, 1, 1));
        vt.push_back(mk(1, 'h200,  0, 0,     0, 0,  1, 0, 'h100,  0,     0, 1, 1, 0));
        vt.push_back(mk(1, 'h300,  0, 0,     0, 0,  1, 0, 'h200,  0,     1, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,     2, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,     2, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 1,  0, 0, 0,      0,     2, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 1,  1, 0, 'h300,  0,     1, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,     1, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 1,  0, 0, 0,      0,     1, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,     0, 1, 1, 1));
        // write FIFO fills under stall, fifth push refused
        vt.push_back(mk(0, 0,      1, 'h10,  1, 0,  0, 0, 0,      0,     0, 1, 1, 1));
        vt.push_back(mk(0, 0,      1, 'h20,  1, 0,  0, 1, 0,      'h10,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      1, 'h30,  1, 0,  0, 1, 0,      'h10,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      1, 'h40,  1, 0,  0, 1, 0,      'h10,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      1, 'h50,  1, 0,  0, 1, 0,      'h10,  0, 1, 0, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 1, 0,      'h10,  0, 1, 0, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 1, 0,      'h20,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 1, 0,      'h30,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 1, 0,      'h40,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,     0, 1, 1, 1));
        // write then read to the same line
        vt.push_back(mk(0, 0,      1, 'h40,  1, 0,  0, 0, 0,      0,     0, 1, 1, 1));
        vt.push_back(mk(1, 'h48,   0, 0,     1, 0,  0, 1, 0,      'h40,  0, 1, 1, 0));
`ifdef MEMREQ_RAW_ORDER_EN
        vt.push_back(mk(0, 0,      0, 0,     1, 0,  0, 1, 0,      'h40,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 1, 0,      'h40,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  1, 0, 'h48,   0,     0, 1, 1, 0));
`else
        vt.push_back(mk(0, 0,      0, 0,     1, 0,  1, 1, 'h48,   'h40,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  1, 1, 'h48,   'h40,  0, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,     1, 1, 1, 0));
`endif
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,     1, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 1,  0, 0, 0,      0,     1, 1, 1, 0));
        vt.push_back(mk(0, 0,      0, 0,     0, 0,  0, 0, 0,      0,     0, 1, 1, 1));

        // reset state, before any clock edge
        #2;
        chk("reset rden", 64'(mem_rden), 64'(0));
        chk("reset wren", 64'(mem_wren), 64'(0));
        chk("reset outstanding", 64'(rd_outstanding), 64'(0));
        chk("reset idle", 64'(idle), 64'(1));
        chk("reset cnt_err", 64'(cnt_err), 64'(0));
        chk("reset rd_ready", 64'(req_rd_ready), 64'(1));
        chk("reset wr_ready", 64'(req_wr_ready), 64'(1));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].rv, vt[i].ra, vt[i].wv, vt[i].wa, vt[i].st, vt[i].rsp);
            #1;
            chk($sformatf("v%0d rden", i), 64'(mem_rden), 64'(vt[i].e_rden));
            chk($sformatf("v%0d wren", i), 64'(mem_wren), 64'(vt[i].e_wren));
            chk($sformatf("v%0d outstanding", i), 64'(rd_outstanding), 64'(vt[i].e_out));
            chk($sformatf("v%0d rd_ready", i), 64'(req_rd_ready), 64'(vt[i].e_rrdy));
            chk($sformatf("v%0d wr_ready", i), 64'(req_wr_ready), 64'(vt[i].e_wrdy));
            chk($sformatf("v%0d idle", i), 64'(idle), 64'(vt[i].e_idle));
            if (vt[i].e_rden) begin
                chk($sformatf("v%0d rdaddr", i), 64'(mem_rdaddr0), 64'(vt[i].e_ra));
                chk($sformatf("v%0d rdphy", i), 64'(mem_rdphydata0), 64'(phy_of(vt[i].e_ra)));
            end
            if (vt[i].e_wren) begin
                chk($sformatf("v%0d wraddr", i), 64'(mem_wraddr0), 64'(vt[i].e_wa));
                checks++;
                if (mem_wrdata !== wdata_of(vt[i].e_wa)) begin
                    errors++;
                    $display("FAIL v%0d wrdata: got hi %0h lo %0h expected for addr %0h", i,
                             mem_wrdata[532:494], mem_wrdata[38:0], vt[i].e_wa);
                end
            end
        end
        chk("cnt_err clear after table", 64'(cnt_err), 64'(0));

        // spurious return sets the sticky error
        @(negedge clk); drive(0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("err set", 64'(cnt_err), 64'(1));
        chk("err count held at 0", 64'(rd_outstanding), 64'(0));
        repeat (3) @(negedge clk);
        #1;
        chk("err sticky", 64'(cnt_err), 64'(1));

        // one read in flight, then queue more under stall and reset asynchronously
        @(negedge clk); drive(1, 'h500, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 'h600, 1, 'h700, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 1, 0);
        #1;
        chk("pre-reset outstanding", 64'(rd_outstanding), 64'(1));
        chk("pre-reset rden", 64'(mem_rden), 64'(1));
        chk("pre-reset wren", 64'(mem_wren), 64'(1));
        #1 rst = 1'b0;
        #1;
        chk("async rst rden", 64'(mem_rden), 64'(0));
        chk("async rst wren", 64'(mem_wren), 64'(0));
        chk("async rst outstanding", 64'(rd_outstanding), 64'(0));
        chk("async rst idle", 64'(idle), 64'(1));
        chk("async rst cnt_err", 64'(cnt_err), 64'(0));
        @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("post-reset queue discarded", 64'(idle), 64'(1));
        chk("post-reset rd_ready", 64'(req_rd_ready), 64'(1));
        @(negedge clk); drive(0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("late return trips err", 64'(cnt_err), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
